// File: rtl/flash_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flash_arb_pkg
//  Description : Shared types and constants for the SPI flash read arbiter
//                and the engine it drives.
//                - arb_state_t : arbiter FSM state encoding
//                - default ADDR_W / LEN_W / MAX_LEN
//                - c_read_cmd  : flash READ opcode used by the engine
//  Revision    : 1.0 - initial release
// ============================================================================
package flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } arb_state_t;

    localparam int c_addr_w_def  = 24;
    localparam int c_len_w_def   = 6;
    localparam int c_max_len_def = 32;

    // Plain READ opcode; the engine prefixes every command with it.
    localparam logic [7:0] c_read_cmd = 8'h03;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin arbiter. Grants the first
//                set request bit at or after the pointer, wrapping around.
//  Ports       : req [NREQ]      request vector
//                ptr [log2 NREQ] highest-priority position
//                gnt [NREQ]      one-hot grant (all zero when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt
);

    logic [NREQ-1:0] w_mask_hi;
    logic [NREQ-1:0] w_hi_gnt;
    logic [NREQ-1:0] w_lo_gnt;

    // Requests at or above the pointer win first; if none, wrap to the
    // lowest set bit overall. x & -x isolates the lowest set bit.
    assign w_mask_hi = req & ~((NREQ'(1) << ptr) - NREQ'(1));
    assign w_hi_gnt  = w_mask_hi & (~w_mask_hi + NREQ'(1));
    assign w_lo_gnt  = req & (~req + NREQ'(1));
    assign gnt       = (|w_mask_hi) ? w_hi_gnt : w_lo_gnt;

endmodule
`default_nettype wire

// File: rtl/flash_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : flash_read_arbiter
//  Description : Shares one SPI flash read engine between NREQ requesters.
//                Round-robin grant, one command per grant, returned bytes
//                steered to the grantee, then a one-cycle done (plus err on
//                an abnormal finish). All outputs are registered.
//  Ports       : clk, rst (sync, active high)
//                req/req_addr/req_len    requester side (packed per index)
//                gnt/rd_data/rd_valid/done/err   requester responses
//                eng_ready/eng_byte_valid/eng_byte/eng_done   from engine
//                eng_start/eng_addr/eng_len/eng_abort         to engine
//  Options     : FLASH_ARB_TIMEOUT_EN - adds a watchdog that aborts a hung
//                engine after TIMEOUT_CYCLES; otherwise eng_abort is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int NREQ           = 3,
    parameter int ADDR_W         = c_addr_w_def,
    parameter int LEN_W          = c_len_w_def,
    parameter int MAX_LEN        = c_max_len_def,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*LEN_W-1:0]  req_len,
    output logic [NREQ-1:0]        gnt,
    output logic [7:0]             rd_data,
    output logic [NREQ-1:0]        rd_valid,
    output logic [NREQ-1:0]        done,
    output logic                   err,
    input  logic                   eng_ready,
    output logic                   eng_start,
    output logic [ADDR_W-1:0]      eng_addr,
    output logic [LEN_W-1:0]       eng_len,
    input  logic                   eng_byte_valid,
    input  logic [7:0]             eng_byte,
    input  logic                   eng_done,
    output logic                   eng_abort
);

    localparam int                PTR_W      = $clog2(NREQ);
    localparam logic [PTR_W-1:0]  c_last_idx = PTR_W'(NREQ - 1);
    localparam logic [LEN_W-1:0]  c_max_len  = LEN_W'(MAX_LEN);

    arb_state_t        r_state,    w_state_nx;
    logic [NREQ-1:0]   r_gnt,      w_gnt_nx;
    logic [PTR_W-1:0]  r_gidx,     w_gidx_nx;
    logic [PTR_W-1:0]  r_ptr,      w_ptr_nx;
    logic [ADDR_W-1:0] r_addr,     w_addr_nx;
    logic [LEN_W-1:0]  r_len,      w_len_nx;
    logic [LEN_W-1:0]  r_cnt,      w_cnt_nx;
    logic              r_errf,     w_errf_nx;
    logic [7:0]        r_rd_data,  w_rd_data_nx;
    logic [NREQ-1:0]   r_rd_valid, w_rd_valid_nx;
    logic [NREQ-1:0]   r_done,     w_done_nx;
    logic              r_err,      w_err_nx;
    logic              r_start,    w_start_nx;

    logic [NREQ-1:0]   w_arb_gnt;
    logic [PTR_W-1:0]  w_win_idx;
    logic [ADDR_W-1:0] w_win_addr;
    logic [LEN_W-1:0]  w_win_len_raw;
    logic [LEN_W-1:0]  w_win_len;
    logic              w_take;
    logic [LEN_W-1:0]  w_cnt_eff;
    logic              w_timeout;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_arb_gnt)
    );

    // Pull the winner's command fields out of the packed request buses.
    always_comb begin
        w_win_idx     = '0;
        w_win_addr    = '0;
        w_win_len_raw = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_gnt[i]) begin
                w_win_idx     = PTR_W'(i);
                w_win_addr    = req_addr[i*ADDR_W +: ADDR_W];
                w_win_len_raw = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign w_win_len = (w_win_len_raw > c_max_len) ? c_max_len : w_win_len_raw;

    // Bytes beyond the requested length are silently dropped.
    assign w_take    = eng_byte_valid && (r_cnt < r_len);
    assign w_cnt_eff = w_take ? (r_cnt + LEN_W'(1)) : r_cnt;

    always_comb begin
        w_state_nx    = r_state;
        w_gnt_nx      = r_gnt;
        w_gidx_nx     = r_gidx;
        w_ptr_nx      = r_ptr;
        w_addr_nx     = r_addr;
        w_len_nx      = r_len;
        w_cnt_nx      = r_cnt;
        w_errf_nx     = r_errf;
        w_rd_data_nx  = r_rd_data;
        w_rd_valid_nx = '0;
        w_done_nx     = '0;
        w_err_nx      = 1'b0;
        w_start_nx    = 1'b0;

        case (r_state)
            IDLE: begin
                if (eng_ready && (|req)) begin
                    w_gnt_nx   = w_arb_gnt;
                    w_gidx_nx  = w_win_idx;
                    w_addr_nx  = w_win_addr;
                    w_len_nx   = w_win_len;
                    w_errf_nx  = 1'b0;
                    // Zero-length requests complete without touching the engine.
                    w_state_nx = (w_win_len == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                w_start_nx = 1'b1;
                w_cnt_nx   = '0;
                w_state_nx = STREAM;
                if (w_timeout) begin
                    w_errf_nx  = 1'b1;
                    w_state_nx = FINISH;
                end
            end
            STREAM: begin
                if (w_take) begin
                    w_rd_data_nx  = eng_byte;
                    w_rd_valid_nx = r_gnt;
                    w_cnt_nx      = w_cnt_eff;
                end
                // eng_done may share a cycle with the final byte; count it first.
                if (eng_done) begin
                    w_errf_nx  = (w_cnt_eff < r_len);
                    w_state_nx = FINISH;
                end else if (w_timeout) begin
                    w_errf_nx  = 1'b1;
                    w_state_nx = FINISH;
                end
            end
            FINISH: begin
                w_done_nx  = r_gnt;
                w_err_nx   = r_errf;
                w_gnt_nx   = '0;
                w_ptr_nx   = (r_gidx == c_last_idx) ? '0 : (r_gidx + PTR_W'(1));
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gidx     <= '0;
            r_ptr      <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_errf     <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_start    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_gnt      <= w_gnt_nx;
            r_gidx     <= w_gidx_nx;
            r_ptr      <= w_ptr_nx;
            r_addr     <= w_addr_nx;
            r_len      <= w_len_nx;
            r_cnt      <= w_cnt_nx;
            r_errf     <= w_errf_nx;
            r_rd_data  <= w_rd_data_nx;
            r_rd_valid <= w_rd_valid_nx;
            r_done     <= w_done_nx;
            r_err      <= w_err_nx;
            r_start    <= w_start_nx;
        end
    end

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wdog, w_wdog_nx;
    logic            r_abort;
    logic            w_active;

    assign w_active = (r_state == ISSUE) || (r_state == STREAM);

    // Counts busy cycles since the last engine byte; idle states clear it.
    always_comb begin
        w_wdog_nx = '0;
        if (w_active) begin
            w_wdog_nx = ((r_state == STREAM) && eng_byte_valid) ? '0 : (r_wdog + WD_W'(1));
        end
    end

    // A normal eng_done in the same cycle wins over the watchdog.
    assign w_timeout = w_active && (w_wdog_nx == WD_W'(TIMEOUT_CYCLES))
                       && !((r_state == STREAM) && eng_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog  <= '0;
            r_abort <= 1'b0;
        end else begin
            r_wdog  <= w_wdog_nx;
            r_abort <= w_timeout;
        end
    end

    assign eng_abort = r_abort;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign eng_abort        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    assign gnt       = r_gnt;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign done      = r_done;
    assign err       = r_err;
    assign eng_start = r_start;
    assign eng_addr  = r_addr;
    assign eng_len   = r_len;

endmodule
`default_nettype wire

// File: tb/tb_flash_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flash_read_arbiter
//  Description : Self-checking bench for flash_read_arbiter. A behavioural
//                engine drives bytes; expected (requester, byte) pairs are
//                queued as they are sent and popped by a monitor on rd_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_read_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 24;
    localparam int LEN_W  = 6;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic [NREQ-1:0]        gnt;
    logic [7:0]             rd_data;
    logic [NREQ-1:0]        rd_valid;
    logic [NREQ-1:0]        done;
    logic                   err;
    logic                   eng_ready;
    logic                   eng_start;
    logic [ADDR_W-1:0]      eng_addr;
    logic [LEN_W-1:0]       eng_len;
    logic                   eng_byte_valid;
    logic [7:0]             eng_byte;
    logic                   eng_done;
    logic                   eng_abort;

    int n_total   = 0;
    int n_pass    = 0;
    int n_strobes = 0;
    int n_abort   = 0;

    // Entry = {one-hot requester, byte}
    logic [NREQ+7:0] sb_q[$];

    flash_read_arbiter #(
        .NREQ           (NREQ),
        .ADDR_W         (ADDR_W),
        .LEN_W          (LEN_W),
        .MAX_LEN        (32),
        .TIMEOUT_CYCLES (4096)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .gnt            (gnt),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .done           (done),
        .err            (err),
        .eng_ready      (eng_ready),
        .eng_start      (eng_start),
        .eng_addr       (eng_addr),
        .eng_len        (eng_len),
        .eng_byte_valid (eng_byte_valid),
        .eng_byte       (eng_byte),
        .eng_done       (eng_done),
        .eng_abort      (eng_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte scoreboard monitor
    always @(negedge clk) begin
        logic [NREQ+7:0] exp_e;
        if (eng_abort) n_abort++;
        if (rd_valid !== '0) begin
            n_strobes++;
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got rd_valid=%b rd_data=%h, expected no strobe", rd_valid, rd_data);
            end else begin
                exp_e = sb_q.pop_front();
                if ({rd_valid, rd_data} !== exp_e)
                    $display("FAIL sb_byte: got rd_valid=%b rd_data=%h, expected rd_valid=%b rd_data=%h",
                             rd_valid, rd_data, exp_e[NREQ+7:8], exp_e[7:0]);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_len[i*LEN_W +: LEN_W]    = l;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        while (!eng_start && lat < 50) begin
            tick();
            lat++;
        end
        n_total++;
        if (!eng_start) $display("FAIL start_timeout: got eng_start=0 after %0d cycles, expected 1", lat);
        else n_pass++;
    endtask

    task automatic wait_done(output logic [NREQ-1:0] d, output logic e, output logic [NREQ-1:0] g);
        int c;
        c = 0;
        d = '0;
        e = 1'b0;
        g = '0;
        while (c < 200) begin
            tick();
            c++;
            if (done !== '0) begin
                d = done;
                e = err;
                g = gnt;
                break;
            end
        end
        n_total++;
        if (d === '0) $display("FAIL done_timeout: got no done after %0d cycles, expected a done pulse", c);
        else n_pass++;
    endtask

    // Drive n_send engine bytes; only the first n_push are expected back.
    task automatic send_bytes(input int idx, input int n_send, input int n_push,
                              input logic [7:0] base, input bit done_last);
        for (int i = 0; i < n_send; i++) begin
            eng_byte_valid = 1'b1;
            eng_byte       = base + 8'(i);
            eng_done       = done_last && (i == n_send - 1);
            if (i < n_push) sb_q.push_back({oh(idx), base + 8'(i)});
            tick();
        end
        eng_byte_valid = 1'b0;
        eng_done       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        req_addr = '0;
        req_len = '0;
        eng_ready = 1'b1;
        eng_byte_valid = 1'b0;
        eng_byte = '0;
        eng_done = 1'b0;
        tick();
        tick();
        n_total++;
        if ({gnt, rd_valid, done, err, eng_start, eng_abort} !== '0)
            $display("FAIL reset_outputs: got gnt=%b rd_valid=%b done=%b err=%b start=%b abort=%b, expected all 0",
                     gnt, rd_valid, done, err, eng_start, eng_abort);
        else n_pass++;
        n_total++;
        if ({eng_addr, eng_len, rd_data} !== '0)
            $display("FAIL reset_cmd: got addr=%h len=%0d data=%h, expected 0", eng_addr, eng_len, rd_data);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int lat, s0;
        logic [NREQ-1:0] d, g;
        logic e;
        s0 = n_strobes;
        set_req(0, 24'h000100, 6'd4);
        req = 3'b001;
        wait_start(lat);
        n_total++;
        if (lat !== 2) $display("FAIL single_latency: got %0d, expected 2", lat);
        else n_pass++;
        n_total++;
        if ({gnt, eng_addr, eng_len} !== {3'b001, 24'h000100, 6'd4})
            $display("FAIL single_cmd: got gnt=%b addr=%h len=%0d, expected 001 000100 4", gnt, eng_addr, eng_len);
        else n_pass++;
        send_bytes(0, 4, 4, 8'hA0, 1'b1);
        wait_done(d, e, g);
        req = '0;
        n_total++;
        if ({d, e} !== {3'b001, 1'b0}) $display("FAIL single_done: got done=%b err=%b, expected 001 0", d, e);
        else n_pass++;
        n_total++;
        if (n_strobes - s0 !== 4) $display("FAIL single_strobes: got %0d, expected 4", n_strobes - s0);
        else n_pass++;
    endtask

    task automatic test_eng_ready();
        int lat;
        logic [NREQ-1:0] d, g;
        logic e;
        eng_ready = 1'b0;
        set_req(1, 24'h000200, 6'd1);
        req = 3'b010;
        repeat (5) tick();
        n_total++;
        if (gnt !== 3'b000) $display("FAIL ready_hold: got gnt=%b, expected 000", gnt);
        else n_pass++;
        eng_ready = 1'b1;
        wait_start(lat);
        send_bytes(1, 1, 1, 8'h55, 1'b1);
        wait_done(d, e, g);
        req = '0;
        n_total++;
        if (d !== 3'b010) $display("FAIL ready_done: got done=%b, expected 010", d);
        else n_pass++;
    endtask

    task automatic test_contention();
        int lat;
        int order[4] = '{0, 1, 2, 0};
        logic [NREQ-1:0] d, g;
        logic e;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 24'h001000 + 24'(i), 6'd1);
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_start(lat);
            n_total++;
            if (gnt !== oh(order[k])) $display("FAIL rr_grant%0d: got gnt=%b, expected %b", k, gnt, oh(order[k]));
            else n_pass++;
            send_bytes(order[k], 1, 1, 8'h10 + 8'(k), 1'b1);
            wait_done(d, e, g);
            if (k == 3) req = '0;
            n_total++;
            if (d !== oh(order[k])) $display("FAIL rr_done%0d: got done=%b, expected %b", k, d, oh(order[k]));
            else n_pass++;
            n_total++;
            if (g !== 3'b000) $display("FAIL rr_gap%0d: got gnt=%b at done, expected 000", k, g);
            else n_pass++;
        end
    endtask

    task automatic test_len_zero();
        int gcyc, starts, c;
        gcyc = 0;
        starts = 0;
        c = 0;
        set_req(2, 24'h003000, 6'd0);
        req = 3'b100;
        while (c < 50) begin
            tick();
            c++;
            if (gnt[2]) gcyc++;
            if (eng_start) starts++;
            if (done !== '0) break;
        end
        req = '0;
        n_total++;
        if ({done, err} !== {3'b100, 1'b0}) $display("FAIL len0_done: got done=%b err=%b, expected 100 0", done, err);
        else n_pass++;
        n_total++;
        if (gcyc !== 1) $display("FAIL len0_gnt_cycles: got %0d, expected 1", gcyc);
        else n_pass++;
        n_total++;
        if (starts !== 0) $display("FAIL len0_start: got %0d eng_start pulses, expected 0", starts);
        else n_pass++;
    endtask

    task automatic test_clamp();
        int lat, s0;
        logic [NREQ-1:0] d, g;
        logic e;
        s0 = n_strobes;
        set_req(1, 24'h123456, 6'd40);
        req = 3'b010;
        wait_start(lat);
        n_total++;
        if (eng_len !== 6'd32) $display("FAIL clamp_len: got %0d, expected 32", eng_len);
        else n_pass++;
        send_bytes(1, 33, 32, 8'h40, 1'b1);
        wait_done(d, e, g);
        req = '0;
        n_total++;
        if ({d, e} !== {3'b010, 1'b0}) $display("FAIL clamp_done: got done=%b err=%b, expected 010 0", d, e);
        else n_pass++;
        n_total++;
        if (n_strobes - s0 !== 32) $display("FAIL clamp_strobes: got %0d, expected 32", n_strobes - s0);
        else n_pass++;
    endtask

    task automatic test_early_done();
        int lat, s0;
        logic [NREQ-1:0] d, g;
        logic e;
        s0 = n_strobes;
        set_req(0, 24'h004000, 6'd8);
        req = 3'b001;
        wait_start(lat);
        send_bytes(0, 2, 2, 8'hC0, 1'b0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        wait_done(d, e, g);
        req = '0;
        n_total++;
        if ({d, e} !== {3'b001, 1'b1}) $display("FAIL early_done: got done=%b err=%b, expected 001 1", d, e);
        else n_pass++;
        n_total++;
        if (n_strobes - s0 !== 2) $display("FAIL early_strobes: got %0d, expected 2", n_strobes - s0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stream();
        int lat, dn;
        set_req(1, 24'h005000, 6'd8);
        req = 3'b010;
        wait_start(lat);
        send_bytes(1, 3, 3, 8'hE0, 1'b0);
        rst = 1'b1;
        tick();
        n_total++;
        if ({gnt, rd_valid, done, err, eng_start, eng_abort} !== '0)
            $display("FAIL midrst_outputs: got gnt=%b rd_valid=%b done=%b err=%b start=%b, expected all 0",
                     gnt, rd_valid, done, err, eng_start);
        else n_pass++;
        rst = 1'b0;
        req = '0;
        dn = 0;
        repeat (6) begin
            tick();
            if (done !== '0) dn++;
        end
        n_total++;
        if (dn !== 0) $display("FAIL midrst_no_done: got %0d done pulses, expected 0", dn);
        else n_pass++;
    endtask

`ifdef FLASH_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int c;
        logic [NREQ-1:0] d, g;
        logic e;
        set_req(0, 24'h006000, 6'd4);
        req = 3'b001;
        c = 0;
        while (gnt === '0 && c < 20) begin
            tick();
            c++;
        end
        c = 0;
        while (!eng_abort && c < 5000) begin
            tick();
            c++;
        end
        n_total++;
        if (c !== 4096) $display("FAIL timeout_cycles: got abort after %0d cycles, expected 4096", c);
        else n_pass++;
        wait_done(d, e, g);
        req = '0;
        n_total++;
        if ({d, e} !== {3'b001, 1'b1}) $display("FAIL timeout_done: got done=%b err=%b, expected 001 1", d, e);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_eng_ready();
        test_contention();
        test_len_zero();
        test_clamp();
        test_early_done();
        test_reset_mid_stream();
`ifdef FLASH_ARB_TIMEOUT_EN
        test_timeout();
`else
        n_total++;
        if (n_abort !== 0) $display("FAIL abort_tied: got %0d abort pulses, expected 0", n_abort);
        else n_pass++;
`endif
        repeat (3) tick();
        n_total++;
        if (sb_q.size() !== 0) $display("FAIL sb_leftover: got %0d pending bytes, expected 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares the single SPI flash read engine between several requesters, e.g. CPU program fetch, text-engine character ROM and a boot loader.
- Each requester posts a start address and a byte count. The arbiter grants one requester at a time in round-robin order and issues the read to the engine.
- Returned bytes are steered to the granted requester, followed by a completion pulse.
- Sits between the requesters and the SPI engine, which owns flash_clk, flash_cs and flash_MOSI.

Parameters:
- NREQ, 3, number of requesters (2..8)
- ADDR_W, 24, flash byte address width
- LEN_W, 6, byte-count field width
- MAX_LEN, 32, largest legal burst (engine buffer size)
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with FLASH_ARB_TIMEOUT_EN

Ports:
- clk  in  1  system clock (27 MHz)
- rst  in  1  synchronous active-high reset
- req  in  NREQ  per-requester request level
- req_addr  in  NREQ*ADDR_W  packed start addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_len  in  NREQ*LEN_W  packed byte counts
- gnt  out  NREQ  one-hot grant, high for the whole transaction
- rd_data  out  8  returned byte, shared by all requesters
- rd_valid  out  NREQ  one-hot strobe qualifying rd_data
- done  out  NREQ  one-cycle completion pulse
- err  out  1  one-cycle pulse alongside done on an abnormal finish
- eng_ready  in  1  engine idle and able to accept a command
- eng_start  out  1  one-cycle command strobe
- eng_addr  out  ADDR_W  command address, held while gnt is nonzero
- eng_len  out  LEN_W  command length, held while gnt is nonzero
- eng_byte_valid  in  1  engine byte strobe
- eng_byte  in  8  engine byte
- eng_done  in  1  engine finished the burst
- eng_abort  out  1  abort strobe to the engine

Behaviour:
- Reset (sync rst=1): state IDLE; all outputs 0; rr pointer 0; byte counter 0. A reset mid-transaction abandons it with no done pulse. The engine shares rst.
- Requester contract:
  - Hold req high and addr/len stable until done.
  - Dropping req mid-transaction is ignored: the transaction completes and done still pulses.
  - Keeping req high after done re-requests.
- len rules:
  - Legal range is 1..MAX_LEN.
  - len>MAX_LEN is clamped to MAX_LEN.
  - len=0 is granted, then finishes with done and no engine command: IDLE -> FINISH, gnt high one cycle.
- Arbitration:
  - Round-robin starting at the rr pointer.
  - After done, rr = grantee+1 mod NREQ.
  - Evaluation is combinational on req.
  - Simultaneous requests go to the first set bit at or after the pointer.
- FSM:
  - IDLE: when eng_ready=1 and |req, latch winner, addr and clamped len; set gnt; go to ISSUE, or to FINISH if len=0. When eng_ready=0, wait.
  - ISSUE: eng_start=1 for exactly one cycle; counter=0; go to STREAM. Command latency is 2 cycles from req to eng_start.
  - STREAM, byte handling: each eng_byte_valid while counter<len registers eng_byte into rd_data and pulses rd_valid[g] one cycle later; counter increments. Bytes with counter>=len are dropped.
  - STREAM, exit: when counter reaches len, wait for eng_done, which may coincide with the last byte, then go to FINISH. If eng_done arrives with counter<len, go to FINISH with err.
  - FINISH: done[g]=1 and err if flagged; gnt cleared; rr updated; go to IDLE. A new grant is earliest in the next IDLE cycle, so there is at least one idle cycle between grants.
- eng_byte_valid outside STREAM is ignored.
- counter width is LEN_W; no wrap occurs because len<=MAX_LEN<2^LEN_W.

Optional Feature:
- Macro: FLASH_ARB_TIMEOUT_EN.
- With the macro:
  - A watchdog counts cycles in ISSUE/STREAM and resets on every eng_byte_valid.
  - On reaching TIMEOUT_CYCLES: eng_abort pulses one cycle, and the FSM goes to FINISH with err=1.
  - The arbiter then waits in IDLE until eng_ready before the next grant.
- Without the macro: no watchdog logic; eng_abort is tied 0. A hung engine stalls the arbiter indefinitely.

Decomposition:
- Package flash_arb_pkg holds:
  - state enum: IDLE, ISSUE, STREAM, FINISH
  - defaults ADDR_W=24, LEN_W=6, MAX_LEN=32
  - read command constant 8'h03 shared with the engine
- Sub-module rr_arbiter (NREQ): inputs req, pointer; output one-hot grant; purely combinational, reused by later bus arbiters.

Test Plan:
- Single request: req[0], addr 0x000100, len 4; engine returns A0..A3 -> eng_start 2 cycles after req; four rd_valid[0] strobes with A0..A3; done[0]; err=0.
- Contention, pointer 0: req=3'b111, each len 1 -> grants in order 0,1,2, then 0 again if still requested; at least one idle cycle between grants.
- len=0 on requester 2 -> gnt[2] high one cycle, done[2] pulse, eng_start never asserted.
- len 40 -> eng_len=32; engine sends 33 bytes -> 32 rd_valid strobes; 33rd byte dropped.
- Early eng_done after 2 of 8 bytes -> done plus err pulse.
- With FLASH_ARB_TIMEOUT_EN: engine silent -> eng_abort and err after 4096 cycles. rst asserted mid-STREAM -> next cycle all outputs 0, no done.
